// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states
// and the alignment check used when a request is accepted.
package lsu_pkg;

    localparam int unsigned LSU_DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_e;

    // Illegal size counts as misaligned so one test covers every error cause.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane handling: extracts and extends load data, and merges
// store data into the word read back from memory.
module lsu_align
    import lsu_pkg::*;
(
    input  size_e                  size_i,
    input  logic [1:0]             lane_i,
    input  logic                   unsigned_i,
    input  logic [LSU_DATA_W-1:0]  wdata_i,
    input  logic [LSU_DATA_W-1:0]  rword_i,
    output logic [LSU_DATA_W-1:0]  ldata_o,
    output logic [LSU_DATA_W-1:0]  mword_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = rword_i[{lane_i, 3'b000} +: 8];
    assign half_s = rword_i[{lane_i[1], 4'b0000} +: 16];

    // Load path: select lane, then sign- or zero-extend.
    always_comb begin
        ldata_o = {LSU_DATA_W{1'b0}};
        case (size_i)
            SZ_BYTE: ldata_o = {{(LSU_DATA_W-8){byte_s[7] & ~unsigned_i}}, byte_s};
            SZ_HALF: ldata_o = {{(LSU_DATA_W-16){half_s[15] & ~unsigned_i}}, half_s};
            SZ_WORD: ldata_o = rword_i;
            default: ldata_o = {LSU_DATA_W{1'b0}};
        endcase
    end

    // Store path: overwrite only the addressed lane(s) of the captured word.
    always_comb begin
        mword_o = rword_i;
        case (size_i)
            SZ_BYTE: mword_o[{lane_i, 3'b000} +: 8]     = wdata_i[7:0];
            SZ_HALF: mword_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            SZ_WORD: mword_o = wdata_i;
            default: mword_o = rword_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage in front of a word-only data memory; sub-word stores run
// read-modify-write. Optional LSU_STATS_EN adds saturating load/store/error counters.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef LSU_STATS_EN
    ,
    output logic [15:0]       cnt_loads,
    output logic [15:0]       cnt_stores,
    output logic [15:0]       cnt_errs
`endif
);

    state_e              state_q, state_d;
    logic                we_q, we_d;
    size_e               size_q, size_d;
    logic                uns_q, uns_d;
    logic [1:0]          lane_q, lane_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;

    logic [DATA_W-1:0]   load_s;
    logic [DATA_W-1:0]   merged_s;

    lsu_align u_align (
        .size_i     (size_q),
        .lane_i     (lane_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .rword_i    (mem_rdata),
        .ldata_o    (load_s),
        .mword_o    (merged_s)
    );

    // Next-state and registered-output decode; outputs are computed for the state being entered.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = {DATA_W{1'b0}};
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = size_e'(req_size);
                    uns_d   = req_unsigned;
                    lane_d  = req_addr[1:0];
                    wdata_d = req_wdata;
                    if (is_misaligned(size_e'(req_size), req_addr[1:0])) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (!req_we || (size_e'(req_size) != SZ_WORD)) begin
                        state_d    = READ;
                        mem_addr_d = {2'b00, req_addr[ADDR_W-1:2]};
                    end else begin
                        state_d     = WRITE;
                        mem_addr_d  = {2'b00, req_addr[ADDR_W-1:2]};
                        mem_wdata_d = req_wdata;
                        mem_we_d    = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (we_q) begin
                    state_d     = WRITE;
                    mem_wdata_d = merged_s;
                    mem_we_d    = 1'b1;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_s;
                end
            end
            WRITE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_ready_d = (state_d == IDLE);
    end

    // State, latched request and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            uns_q       <= 1'b0;
            lane_q      <= 2'b00;
            wdata_q     <= {DATA_W{1'b0}};
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= {DATA_W{1'b0}};
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;

`ifdef LSU_STATS_EN
    logic [15:0] cnt_loads_q, cnt_stores_q, cnt_errs_q;

    // Classify each completed response; the latched request is stable during RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_loads_q  <= 16'h0000;
            cnt_stores_q <= 16'h0000;
            cnt_errs_q   <= 16'h0000;
        end else if (rsp_valid_q) begin
            if (rsp_err_q) begin
                if (cnt_errs_q != 16'hFFFF) cnt_errs_q <= cnt_errs_q + 16'd1;
            end else if (we_q) begin
                if (cnt_stores_q != 16'hFFFF) cnt_stores_q <= cnt_stores_q + 16'd1;
            end else begin
                if (cnt_loads_q != 16'hFFFF) cnt_loads_q <= cnt_loads_q + 16'd1;
            end
        end
    end

    assign cnt_loads  = cnt_loads_q;
    assign cnt_stores = cnt_stores_q;
    assign cnt_errs   = cnt_errs_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef LSU_STATS_EN
    logic [15:0] cnt_loads, cnt_stores, cnt_errs;
`endif

    logic [31:0] mem [0:63];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] rdata;
        int          we_cnt;
    } exp_t;
    exp_t sb[$];

    logic [31:0] last_we_addr, last_we_data;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr[5:0]];

    load_store_unit dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata)
`ifdef LSU_STATS_EN
        ,
        .cnt_loads    (cnt_loads),
        .cnt_stores   (cnt_stores),
        .cnt_errs     (cnt_errs)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, push its expectation, then follow it to the response.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata,
                          input int exp_we);
        exp_t e;
        exp_t got;
        int   lat;
        int   we_cnt;
        logic seen;
        e.lat = exp_lat; e.err = exp_err; e.rdata = exp_rdata; e.we_cnt = exp_we;
        sb.push_back(e);
        chk({tag, " ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = ~we; req_size = $urandom_range(3, 0); req_unsigned = ~uns;
        req_addr = $urandom; req_wdata = $urandom;
        lat = 1; we_cnt = 0; seen = 1'b0;
        while (!seen && lat <= 8) begin
            if (mem_we) begin
                we_cnt++;
                last_we_addr = mem_addr;
                last_we_data = mem_wdata;
            end
            if (rsp_valid) begin
                seen = 1'b1;
            end else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        got = sb.pop_front();
        chk({tag, " rsp_seen"}, {31'd0, seen}, 32'd1);
        chk({tag, " latency"}, lat, got.lat);
        chk({tag, " rsp_err"}, {31'd0, rsp_err}, {31'd0, got.err});
        chk({tag, " rsp_rdata"}, rsp_rdata, got.rdata);
        chk({tag, " we_pulses"}, we_cnt, got.we_cnt);
        @(posedge clk); #1;
    endtask

    initial begin
        int vld_cnt;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        @(posedge clk); #1;
        chk("rst req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        do_req("sw78", 1'b1, 2'b10, 1'b0, 32'd24, 32'd78, 2, 1'b0, 32'd0, 1);
        chk("sw78 we_addr", last_we_addr, 32'd6);
        chk("sw78 we_data", last_we_data, 32'd78);
        do_req("lw78", 1'b0, 2'b10, 1'b0, 32'd24, 32'd0, 2, 1'b0, 32'd78, 0);

        do_req("sw_pre", 1'b1, 2'b10, 1'b0, 32'd24, 32'h1122_3344, 2, 1'b0, 32'd0, 1);
        do_req("sb25", 1'b1, 2'b00, 1'b0, 32'd25, 32'hFFFF_FFAB, 3, 1'b0, 32'd0, 1);
        chk("sb25 mem", mem[6], 32'h1122_AB44);
        do_req("lw_sb", 1'b0, 2'b10, 1'b0, 32'd24, 32'd0, 2, 1'b0, 32'h1122_AB44, 0);

        do_req("sw_80ff", 1'b1, 2'b10, 1'b0, 32'd24, 32'h80FF_0000, 2, 1'b0, 32'd0, 1);
        do_req("lb27s", 1'b0, 2'b00, 1'b0, 32'd27, 32'd0, 2, 1'b0, 32'hFFFF_FF80, 0);
        do_req("lb27u", 1'b0, 2'b00, 1'b1, 32'd27, 32'd0, 2, 1'b0, 32'h0000_0080, 0);
        do_req("lh26s", 1'b0, 2'b01, 1'b0, 32'd26, 32'd0, 2, 1'b0, 32'hFFFF_80FF, 0);

        do_req("sh24", 1'b1, 2'b01, 1'b0, 32'd24, 32'h1234_5678, 3, 1'b0, 32'd0, 1);
        chk("sh24 mem", mem[6], 32'h80FF_5678);
        do_req("lb24u", 1'b0, 2'b00, 1'b1, 32'd24, 32'd0, 2, 1'b0, 32'h0000_0078, 0);
        do_req("lh24s", 1'b0, 2'b01, 1'b0, 32'd24, 32'd0, 2, 1'b0, 32'h0000_5678, 0);

        do_req("err_sh25", 1'b1, 2'b01, 1'b0, 32'd25, 32'hDEAD_BEEF, 1, 1'b1, 32'd0, 0);
        do_req("err_lw26", 1'b0, 2'b10, 1'b0, 32'd26, 32'd0, 1, 1'b1, 32'd0, 0);
        do_req("err_sz11", 1'b1, 2'b11, 1'b0, 32'd24, 32'hDEAD_BEEF, 1, 1'b1, 32'd0, 0);
        chk("err mem", mem[6], 32'h80FF_5678);

        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'd24; req_wdata = 32'h0000_0055;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort read mem_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk); #1;
        chk("abort write mem_we", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort mem_we low", {31'd0, mem_we}, 32'd0);
        chk("abort req_ready", {31'd0, req_ready}, 32'd1);
        chk("abort rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk); reset = 1'b0;
        vld_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) vld_cnt++;
        end
        chk("abort no_rsp", vld_cnt, 32'd0);
        chk("abort mem", mem[6], 32'h80FF_5678);

        do_req("st_lw", 1'b0, 2'b10, 1'b0, 32'd24, 32'd0, 2, 1'b0, 32'h80FF_5678, 0);
        do_req("st_lbu", 1'b0, 2'b00, 1'b1, 32'd27, 32'd0, 2, 1'b0, 32'h0000_0080, 0);
        do_req("st_lhu", 1'b0, 2'b01, 1'b1, 32'd26, 32'd0, 2, 1'b0, 32'h0000_80FF, 0);
        do_req("st_sw", 1'b1, 2'b10, 1'b0, 32'd28, 32'hCAFE_F00D, 2, 1'b0, 32'd0, 1);
        do_req("st_sb", 1'b1, 2'b00, 1'b0, 32'd24, 32'h0000_0099, 3, 1'b0, 32'd0, 1);
        chk("st_sb mem", mem[6], 32'h80FF_5699);
        chk("st_sw mem", mem[7], 32'hCAFE_F00D);
        do_req("st_err", 1'b1, 2'b10, 1'b0, 32'd29, 32'd1, 1, 1'b1, 32'd0, 0);
`ifdef LSU_STATS_EN
        chk("cnt_loads", {16'd0, cnt_loads}, 32'd3);
        chk("cnt_stores", {16'd0, cnt_stores}, 32'd2);
        chk("cnt_errs", {16'd0, cnt_errs}, 32'd1);
`endif
        chk("sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
